// File: rtl/lsu_pkg.sv
// Shared types for the miniRV load/store unit.
//   state_t    : transaction FSM states
//   op_t       : latched memory operation
//   WSTRB_WORD : full-word byte-enable mask
//   is_load()  : true for operations that return data to the register file
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_LW  = 2'd0,
    OP_LBU = 2'd1,
    OP_SW  = 2'd2,
    OP_SB  = 2'd3
  } op_t;

  localparam logic [3:0] WSTRB_WORD = 4'hF;

  function automatic logic is_load(op_t op);
    return (op == OP_LW) || (op == OP_LBU);
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory request/acknowledge bus.
//   mem_req   : request, held until ack or abort
//   mem_we    : 1 = write
//   mem_addr  : word-aligned address
//   mem_wdata : write data
//   mem_wstrb : byte enables, bit i = byte lane i
//   mem_ack   : transaction complete, mem_rdata valid in the same cycle
//   mem_rdata : read word
// master = load/store unit, slave = memory.
interface lsu_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lsu_byte_lane.sv
// Combinational byte-lane steering for the load/store unit.
//   op         : memory operation
//   off        : byte offset addr[1:0]
//   store_data : store operand (rs2)
//   rdata      : read word from memory
//   wstrb      : byte enables (zero for loads)
//   wdata      : write word (byte replicated on all lanes for sb)
//   load_val   : aligned, zero-extended load result
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  op_t         op,
  input  logic [1:0]  off,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_val
);

  always_comb begin
    wstrb    = 4'b0000;
    wdata    = store_data;
    load_val = 32'd0;
    unique case (op)
      OP_LW:  load_val = rdata;
      OP_LBU: load_val = {24'd0, rdata[{off, 3'b000} +: 8]};
      OP_SW:  wstrb    = WSTRB_WORD;
      OP_SB: begin
        wstrb = 4'b0001 << off;
        wdata = {4{store_data[7:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle data-memory access unit for the miniRV core.
//   clk, rst        : core clock, asynchronous active-high reset
//   lw/lbu/sw/sb    : decoded op strobes (priority lw > lbu > sw > sb)
//   addr            : effective byte address
//   store_data      : rs2 value
//   bus             : data-memory request/acknowledge bus (master side)
//   read_data       : registered load result, updated on entry to DONE for a load
//   stall           : freeze PC/pipeline while the access is in flight
//   err             : one-cycle pulse in DONE for misaligned or timed-out access
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lw,
  input  logic        lbu,
  input  logic        sw,
  input  logic        sb,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  lsu_if.master       bus,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        err
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  op_t         op_q, op_d, op_sel;
  logic [31:0] addr_q, addr_d;
  logic [31:0] sd_q, sd_d;
  logic [31:0] rd_q, rd_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        op_valid, misaligned;

  logic [3:0]  lane_wstrb;
  logic [31:0] lane_wdata, lane_load;

  always_comb begin
    op_sel = OP_LW;
    if (lw)       op_sel = OP_LW;
    else if (lbu) op_sel = OP_LBU;
    else if (sw)  op_sel = OP_SW;
    else if (sb)  op_sel = OP_SB;
  end

  assign op_valid   = lw | lbu | sw | sb;
  assign misaligned = ((op_sel == OP_LW) || (op_sel == OP_SW)) && (addr[1:0] != 2'b00);

  lsu_byte_lane u_lane (
    .op         (op_q),
    .off        (addr_q[1:0]),
    .store_data (sd_q),
    .rdata      (bus.mem_rdata),
    .wstrb      (lane_wstrb),
    .wdata      (lane_wdata),
    .load_val   (lane_load)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    sd_d    = sd_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (op_valid) begin
          op_d   = op_sel;
          addr_d = addr;
          sd_d   = store_data;
          cnt_d  = 8'd0;
          if (misaligned) begin
            // No bus access: stores are dropped, loads return zero.
            err_d   = 1'b1;
            state_d = DONE;
            if (is_load(op_sel)) rd_d = 32'd0;
          end else begin
            err_d   = 1'b0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        // Ack takes precedence over the timeout in the same cycle.
        if (bus.mem_ack) begin
          state_d = DONE;
          if (is_load(op_q)) rd_d = lane_load;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          err_d   = 1'b1;
          if (is_load(op_q)) rd_d = 32'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_LW;
      addr_q  <= 32'd0;
      sd_q    <= 32'd0;
      rd_q    <= 32'd0;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      sd_q    <= sd_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Bus outputs decode straight from state so reset drops mem_req asynchronously.
  assign bus.mem_req   = (state_q == REQ);
  assign bus.mem_we    = bus.mem_req && !is_load(op_q);
  assign bus.mem_wstrb = bus.mem_req ? lane_wstrb : 4'b0000;
  assign bus.mem_addr  = {addr_q[31:2], 2'b00};
  assign bus.mem_wdata = lane_wdata;

  assign read_data = rd_q;
  assign stall     = ((state_q == IDLE) && op_valid) || (state_q == REQ);
  assign err       = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lw = 1'b0, lbu = 1'b0, sw = 1'b0, sb = 1'b0;
  logic [31:0] addr = 32'd0, store_data = 32'd0;
  logic [31:0] read_data;
  logic        stall, err;

  int tests  = 0;
  int failed = 0;

  lsu_if bus ();

  load_store_unit #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .lw         (lw),
    .lbu        (lbu),
    .sw         (sw),
    .sb         (sb),
    .addr       (addr),
    .store_data (store_data),
    .bus        (bus),
    .read_data  (read_data),
    .stall      (stall),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ops;        // {lw, lbu, sw, sb}
    logic [31:0] a;
    logic [31:0] sd;
    logic [31:0] rdata;
    int          ack_at;     // REQ cycle (1-based) in which ack is given, 0 = never
    int          exp_req;    // expected number of mem_req cycles
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;  // checked only when exp_we
    int          exp_stall;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Entered just after a falling edge with the unit in IDLE.
  task automatic run_vec(input int idx, input vec_t v);
    int  req_cnt = 0;
    int  stall_cnt = 0;
    bit  done = 0;
    {lw, lbu, sw, sb} = v.ops;
    addr       = v.a;
    store_data = v.sd;
    for (int c = 0; c < 64 && !done; c++) begin
      #1;
      if (stall) begin
        stall_cnt++;
        if (bus.mem_req) begin
          req_cnt++;
          if (req_cnt == 1) begin
            check($sformatf("v%0d mem_addr", idx), bus.mem_addr, v.exp_addr);
            check($sformatf("v%0d mem_we", idx), {31'd0, bus.mem_we}, {31'd0, v.exp_we});
            check($sformatf("v%0d mem_wstrb", idx), {28'd0, bus.mem_wstrb}, {28'd0, v.exp_wstrb});
            if (v.exp_we)
              check($sformatf("v%0d mem_wdata", idx), bus.mem_wdata, v.exp_wdata);
          end
          if (v.ack_at != 0 && req_cnt == v.ack_at) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = v.rdata;
          end else begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 32'hBAD0BAD0;
          end
        end
      end else begin
        done = 1;
        check($sformatf("v%0d read_data", idx), read_data, v.exp_rd);
        check($sformatf("v%0d err", idx), {31'd0, err}, {31'd0, v.exp_err});
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'hBAD0BAD0;
        {lw, lbu, sw, sb} = 4'b0000;
      end
      @(negedge clk);
    end
    if (!done) check($sformatf("v%0d done reached", idx), 32'd0, 32'd1);
    check($sformatf("v%0d req cycles", idx), req_cnt, v.exp_req);
    check($sformatf("v%0d stall cycles", idx), stall_cnt, v.exp_stall);
    #1;
    check($sformatf("v%0d err after done", idx), {31'd0, err}, 32'd0);
    check($sformatf("v%0d req after done", idx), {31'd0, bus.mem_req}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    //           ops      addr          sd            rdata         ack req addr          we  wstrb    wdata         stl rd            err
    vecs[0]  = '{4'b1000, 32'h00000100, 32'h0,        32'hDEADBEEF, 3,  3,  32'h00000100, 0,  4'b0000, 32'h0,        4,  32'hDEADBEEF, 0};
    vecs[1]  = '{4'b0100, 32'h00000203, 32'h0,        32'h8A000000, 1,  1,  32'h00000200, 0,  4'b0000, 32'h0,        2,  32'h0000008A, 0};
    vecs[2]  = '{4'b0001, 32'h00000301, 32'h123456A5, 32'h0,        1,  1,  32'h00000300, 1,  4'b0010, 32'hA5A5A5A5, 2,  32'h0000008A, 0};
    vecs[3]  = '{4'b0010, 32'h00000402, 32'h11111111, 32'h0,        1,  0,  32'h0,        0,  4'b0000, 32'h0,        1,  32'h0000008A, 1};
    vecs[4]  = '{4'b1000, 32'h00000500, 32'h0,        32'h0,        0,  16, 32'h00000500, 0,  4'b0000, 32'h0,        17, 32'h00000000, 1};
    vecs[5]  = '{4'b1010, 32'h00000600, 32'hFFFFFFFF, 32'h11223344, 2,  2,  32'h00000600, 0,  4'b0000, 32'h0,        3,  32'h11223344, 0};
    vecs[6]  = '{4'b0010, 32'h00000700, 32'hCAFEF00D, 32'h0,        1,  1,  32'h00000700, 1,  4'b1111, 32'hCAFEF00D, 2,  32'h11223344, 0};
    vecs[7]  = '{4'b0100, 32'h00000701, 32'h0,        32'h0000AB00, 1,  1,  32'h00000700, 0,  4'b0000, 32'h0,        2,  32'h000000AB, 0};
    vecs[8]  = '{4'b1000, 32'h000007FE, 32'h0,        32'h0,        1,  0,  32'h0,        0,  4'b0000, 32'h0,        1,  32'h00000000, 1};
    vecs[9]  = '{4'b1000, 32'h00000800, 32'h0,        32'h55AA55AA, 16, 16, 32'h00000800, 0,  4'b0000, 32'h0,        17, 32'h55AA55AA, 0};
    vecs[10] = '{4'b0001, 32'h00000903, 32'h000000C3, 32'h0,        1,  1,  32'h00000900, 1,  4'b1000, 32'hC3C3C3C3, 2,  32'h55AA55AA, 0};
    vecs[11] = '{4'b0101, 32'h00000900, 32'h00000077, 32'h123456EF, 1,  1,  32'h00000900, 0,  4'b0000, 32'h0,        2,  32'h000000EF, 0};

    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'hBAD0BAD0;

    // Reset state, checked while reset is held.
    repeat (2) @(negedge clk);
    #1;
    check("rst mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("rst mem_wstrb", {28'd0, bus.mem_wstrb}, 32'd0);
    check("rst mem_addr", bus.mem_addr, 32'd0);
    check("rst mem_wdata", bus.mem_wdata, 32'd0);
    check("rst read_data", read_data, 32'd0);
    check("rst err", {31'd0, err}, 32'd0);
    check("rst stall idle", {31'd0, stall}, 32'd0);
    lw = 1'b1;
    #1;
    check("rst stall decode", {31'd0, stall}, 32'd1);
    lw = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Reset asserted in the fifth REQ cycle of an unacknowledged load.
    begin
      int  req_cnt = 0;
      bit  hit = 0;
      lw   = 1'b1;
      addr = 32'h00000A00;
      for (int c = 0; c < 20 && !hit; c++) begin
        #1;
        if (bus.mem_req) req_cnt++;
        if (req_cnt == 5) begin
          hit = 1;
          rst = 1'b1;
          lw  = 1'b0;
          #1;
          check("midreq mem_req drop", {31'd0, bus.mem_req}, 32'd0);
          check("midreq stall", {31'd0, stall}, 32'd0);
          check("midreq read_data", read_data, 32'd0);
        end
        @(negedge clk);
      end
      if (!hit) check("midreq reached", 32'd0, 32'd1);
      rst = 1'b0;
      @(negedge clk);
      #1;
      check("postrst mem_req", {31'd0, bus.mem_req}, 32'd0);
      @(negedge clk);
    end

    // The unit works normally again after the abandoned access.
    run_vec(12, vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle data-memory access unit for the miniRV core. Takes the decoded load/store strobes, the ALU-computed effective address and the store operand. Runs a request/acknowledge transaction on the data-memory bus and stalls the core until the transaction completes. Returns the aligned load result as `read_data`, the memory input of the register-file writeback selection, so it is the producer end of the load path.

## Interface
Parameters:
- `TIMEOUT`, 16: cycles `mem_req` may wait for `mem_ack` before the access is aborted; range 2..255.

Ports:
- `clk`  in  1  core clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `lw`, `lbu`, `sw`, `sb`  in  1 each  decoded op strobes for the current instruction.
- `addr`  in  32  effective byte address (ALU result).
- `store_data`  in  32  rs2 value.
- `mem_req`  out  1  bus request; held until ack or abort.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  32  word-aligned address `{addr[31:2],2'b00}`.
- `mem_wdata`  out  32  write data.
- `mem_wstrb`  out  4  byte enables, bit i = byte lane i.
- `mem_ack`  in  1  transaction complete; `mem_rdata` valid in the same cycle.
- `mem_rdata`  in  32  read word.
- `read_data`  out  32  load result; valid in the DONE cycle, held until the next load completes.
- `stall`  out  1  freeze PC/pipeline.
- `err`  out  1  one-cycle pulse in DONE for a misaligned or timed-out access.

## Operation
- Active op is selected by priority: `lw` > `lbu` > `sw` > `sb`. A lower-priority strobe asserted together with a higher one is ignored.
- States:
  - IDLE: if any op is active, latch op, `addr` and `store_data`.
    - Misaligned (`lw`/`sw` with `addr[1:0]!=0`): go to DONE with error flagged. There is no bus access, and stores are dropped.
    - Otherwise go to REQ.
  - REQ: drive `mem_req`=1 from latched values.
    - On `mem_ack`: capture the load result and go to DONE.
    - If the wait counter reaches TIMEOUT without ack: go to DONE with error, `read_data`=0.
  - DONE: `stall`=0, `err` pulses if flagged. Next state is always IDLE.
- `stall` = (IDLE and an op is active) or REQ. It is combinational from state and strobes.
- Loads:
  - `lw` returns `mem_rdata`.
  - `lbu` returns `{24'b0, lane byte addr[1:0]}`.
  - Error loads return 0.
- Stores:
  - `sw`: `mem_wstrb`=4'hF, `mem_wdata`=`store_data`.
  - `sb`: `mem_wstrb`=`4'b1<<addr[1:0]`, `mem_wdata`=`{4{store_data[7:0]}}`.
- Bus signals when `mem_req`=0: `mem_we`=0, `mem_wstrb`=0; `mem_addr`/`mem_wdata` are don't-care but held at latched values.
- `mem_ack` is ignored outside REQ.
- `mem_rdata` is sampled only in the ack cycle.

## Timing
- Reset values: state IDLE, `mem_req`=0, `mem_we`=0, `mem_wstrb`=0, `mem_addr`=0, `mem_wdata`=0, `read_data`=0, `err`=0, wait counter 0. `stall` reflects IDLE decode.
- Reset asserted mid-REQ: `mem_req` drops asynchronously. The access is abandoned; there is no bus-side cleanup.
- Best case, ack in the first REQ cycle: IDLE(stall) → REQ(stall) → DONE. That is 2 stall cycles and a 3-cycle instruction.
- Each additional REQ cycle without ack adds one stall cycle.
- Misaligned access: IDLE(stall) → DONE, 1 stall cycle.
- Wait counter: cleared on REQ entry and incremented each REQ cycle without ack. An ack in the same cycle the counter reaches TIMEOUT wins and is a normal completion.
- Back-to-back memory ops: DONE → IDLE, then the next op starts. `mem_req` is low for at least 2 cycles between transactions.
- `read_data` is registered and changes only on entry to DONE for a load.

## Structure
- Shared package `lsu_pkg`:
  - state enum (IDLE, REQ, DONE)
  - op encoding (OP_LW, OP_LBU, OP_SW, OP_SB)
  - `WSTRB_WORD`=4'hF
- Sub-module `lsu_byte_lane`, purely combinational. Given op, `addr[1:0]`, `store_data` and `mem_rdata`, it produces `mem_wstrb`, `mem_wdata` and the extracted load value.
- Top module: FSM, latches, wait counter.

## Test plan
- `lw` at addr 0x100, memory acks after 3 REQ cycles with 0xDEADBEEF:
  - `mem_addr`=0x100, `mem_we`=0
  - `stall` high for 4 cycles
  - `read_data`=0xDEADBEEF in DONE, `err`=0
- `lbu` at 0x203 with `mem_rdata`=0x8A000000, ack in the first cycle: `mem_addr`=0x200, `read_data`=0x0000008A (zero-extended), 2 stall cycles.
- `sb` at 0x301, `store_data`=0x123456A5: `mem_wstrb`=4'b0010, `mem_wdata`=0xA5A5A5A5, `mem_we`=1.
- `sw` at 0x402: no `mem_req`, 1 stall cycle, `err` pulses in DONE.
- `lw`, no ack, TIMEOUT=16:
  - `mem_req` high exactly 16 cycles, then DONE with `err`=1, `read_data`=0.
  - Separately, `rst` asserted in REQ cycle 5 drops `mem_req` immediately and the unit returns to IDLE.
- `lw` and `sw` asserted together: the access is a read (`mem_we`=0, `mem_wstrb`=0).
